// File: rtl/ps2_key_rx_if.sv
// PS/2 key receiver bus.
// The host side (master) drives the raw PS/2 lines and watches the key event
// word and the error pulse. The receiver (slave) does the opposite.
//   ps2_clk_i  - raw PS/2 clock line, asynchronous, idle high
//   ps2_data_i - raw PS/2 data line, asynchronous, idle high
//   ps2_key_o  - key event word: [10] toggle, [9] pressed, [8] extended, [7:0] scancode
//   err_o      - one-cycle pulse on a framing, parity or timeout error
interface ps2_key_rx_if;
  logic        ps2_clk_i;
  logic        ps2_data_i;
  logic [10:0] ps2_key_o;
  logic        err_o;

  modport master (
    output ps2_clk_i,
    output ps2_data_i,
    input  ps2_key_o,
    input  err_o
  );

  modport slave (
    input  ps2_clk_i,
    input  ps2_data_i,
    output ps2_key_o,
    output err_o
  );
endinterface

// File: rtl/ps2_key_rx.sv
// PS/2 keyboard receiver.
// Synchronizes and de-glitches both raw PS/2 lines, deframes 11-bit frames
// (start, 8 data LSB first, odd parity, stop) on falling clock edges, and
// folds the E0/F0 prefixes into a single 11-bit key event word.
// Ports:
//   clk_sys - system clock, sole clock of the block
//   reset   - synchronous, active-high reset
//   bus     - ps2_key_rx_if.slave: ps2_clk_i/ps2_data_i in, ps2_key_o/err_o out
// Parameters:
//   FILTER_LEN     - cycles a synchronized line must be stable before a change is accepted
//   TIMEOUT_CYCLES - maximum cycles between falling clock edges inside a frame
// Configuration macro:
//   PS2_KEY_PARITY_CHECK_EN - when defined, frames with bad (even) parity raise err_o
//                             and are discarded; otherwise parity is ignored.
module ps2_key_rx #(
  parameter int unsigned FILTER_LEN     = 8,
  parameter int unsigned TIMEOUT_CYCLES = 50000
) (
  input  logic          clk_sys,
  input  logic          reset,
  ps2_key_rx_if.slave   bus
);

  localparam int unsigned CntW   = $clog2(FILTER_LEN + 1);
  localparam int unsigned TmoW   = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(FILTER_LEN - 1);
  localparam logic [TmoW-1:0] TmoLast = TmoW'(TIMEOUT_CYCLES - 1);

  localparam logic [1:0] StIdle   = 2'd0;
  localparam logic [1:0] StData   = 2'd1;
  localparam logic [1:0] StParity = 2'd2;
  localparam logic [1:0] StStop   = 2'd3;

  // Index 0 = clock line, index 1 = data line.
  logic [1:0]      meta_q, sync_q, filt_q, filt_d;
  logic [CntW-1:0] cnt_q [2];
  logic [CntW-1:0] cnt_d [2];
  logic            clk_prev_q;
  logic            fall;

  logic [1:0]      state_q, state_d;
  logic [2:0]      bitcnt_q, bitcnt_d;
  logic [7:0]      shift_q, shift_d;
  logic [TmoW-1:0] tmo_q, tmo_d;
  logic            ext_q, ext_d;
  logic            brk_q, brk_d;
  logic [10:0]     key_q, key_d;
  logic            err_q, err_d;
`ifdef PS2_KEY_PARITY_CHECK_EN
  logic            par_q, par_d;
`endif

  // A line change is accepted only after FILTER_LEN consecutive differing samples.
  always_comb begin
    filt_d = filt_q;
    for (int i = 0; i < 2; i++) begin
      cnt_d[i] = '0;
      if (sync_q[i] != filt_q[i]) begin
        if (cnt_q[i] == CntLast) begin
          filt_d[i] = sync_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end
    end
  end

  assign fall = clk_prev_q & ~filt_q[0];

  always_comb begin
    state_d  = state_q;
    bitcnt_d = bitcnt_q;
    shift_d  = shift_q;
    tmo_d    = '0;
    ext_d    = ext_q;
    brk_d    = brk_q;
    key_d    = key_q;
    err_d    = 1'b0;
`ifdef PS2_KEY_PARITY_CHECK_EN
    par_d    = par_q;
`endif
    if (state_q != StIdle && !fall && tmo_q == TmoLast) begin
      // Inter-edge gap too long: drop the partial byte.
      state_d  = StIdle;
      bitcnt_d = '0;
      shift_d  = '0;
      err_d    = 1'b1;
      ext_d    = 1'b0;
      brk_d    = 1'b0;
    end else begin
      if (state_q != StIdle && !fall) begin
        tmo_d = tmo_q + 1'b1;
      end
      if (fall) begin
        case (state_q)
          StIdle: begin
            // A falling edge with data high is not a start bit; ignore it.
            if (!filt_q[1]) begin
              state_d  = StData;
              bitcnt_d = '0;
            end
          end
          StData: begin
            shift_d = {filt_q[1], shift_q[7:1]};
            if (bitcnt_q == 3'd7) begin
              state_d  = StParity;
              bitcnt_d = '0;
            end else begin
              bitcnt_d = bitcnt_q + 1'b1;
            end
          end
          StParity: begin
`ifdef PS2_KEY_PARITY_CHECK_EN
            par_d = filt_q[1];
`endif
            // Without the parity check the bit is simply consumed.
            state_d = StStop;
          end
          default: begin
            state_d = StIdle;
            if (!filt_q[1]) begin
              err_d = 1'b1;
              ext_d = 1'b0;
              brk_d = 1'b0;
`ifdef PS2_KEY_PARITY_CHECK_EN
            end else if (!(^{shift_q, par_q})) begin
              err_d = 1'b1;
              ext_d = 1'b0;
              brk_d = 1'b0;
`endif
            end else begin
              case (shift_q)
                8'hE0:   ext_d = 1'b1;
                8'hF0:   brk_d = 1'b1;
                8'hE1:   ;
                default: begin
                  key_d = {~key_q[10], ~brk_q, ext_q, shift_q};
                  ext_d = 1'b0;
                  brk_d = 1'b0;
                end
              endcase
            end
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      meta_q     <= 2'b11;
      sync_q     <= 2'b11;
      filt_q     <= 2'b11;
      cnt_q[0]   <= '0;
      cnt_q[1]   <= '0;
      clk_prev_q <= 1'b1;
      state_q    <= StIdle;
      bitcnt_q   <= '0;
      shift_q    <= '0;
      tmo_q      <= '0;
      ext_q      <= 1'b0;
      brk_q      <= 1'b0;
      key_q      <= '0;
      err_q      <= 1'b0;
`ifdef PS2_KEY_PARITY_CHECK_EN
      par_q      <= 1'b0;
`endif
    end else begin
      meta_q     <= {bus.ps2_data_i, bus.ps2_clk_i};
      sync_q     <= meta_q;
      filt_q     <= filt_d;
      cnt_q[0]   <= cnt_d[0];
      cnt_q[1]   <= cnt_d[1];
      clk_prev_q <= filt_q[0];
      state_q    <= state_d;
      bitcnt_q   <= bitcnt_d;
      shift_q    <= shift_d;
      tmo_q      <= tmo_d;
      ext_q      <= ext_d;
      brk_q      <= brk_d;
      key_q      <= key_d;
      err_q      <= err_d;
`ifdef PS2_KEY_PARITY_CHECK_EN
      par_q      <= par_d;
`endif
    end
  end

  assign bus.ps2_key_o = key_q;
  assign bus.err_o     = err_q;

endmodule

// File: tb/tb_ps2_key_rx.sv
// Directed bench for ps2_key_rx: drives PS/2 frames bit by bit and checks the
// key event word, the number of key updates and the number of err_o pulses.
module tb_ps2_key_rx;
  localparam int unsigned FilterLen     = 4;
  localparam int unsigned TimeoutCycles = 300;
  localparam int unsigned Half          = 20;

  logic clk_sys = 1'b0;
  logic reset   = 1'b1;

  ps2_key_rx_if bus ();

  ps2_key_rx #(
    .FILTER_LEN    (FilterLen),
    .TIMEOUT_CYCLES(TimeoutCycles)
  ) dut (
    .clk_sys(clk_sys),
    .reset  (reset),
    .bus    (bus)
  );

  always #5 clk_sys = ~clk_sys;

  int checks   = 0;
  int failures = 0;
  int err_cnt  = 0;
  int chg_cnt  = 0;
  logic [10:0] key_prev = '0;

  always @(negedge clk_sys) begin
    if (bus.err_o === 1'b1) err_cnt++;
    if (bus.ps2_key_o !== key_prev) chg_cnt++;
    key_prev = bus.ps2_key_o;
  end

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic ps2_bit(input logic b);
    @(negedge clk_sys);
    bus.ps2_data_i = b;
    repeat (Half) @(negedge clk_sys);
    bus.ps2_clk_i = 1'b0;
    repeat (Half) @(negedge clk_sys);
    bus.ps2_clk_i = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic bad_par, input logic stop_b);
    ps2_bit(1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(b[i]);
    ps2_bit(~(^b) ^ bad_par);
    ps2_bit(stop_b);
    bus.ps2_data_i = 1'b1;
    repeat (40) @(negedge clk_sys);
  endtask

  int exp_err;
  int chg0;

  initial begin
    bus.ps2_clk_i  = 1'b1;
    bus.ps2_data_i = 1'b1;
    repeat (4) @(negedge clk_sys);
    check_eq("rst_key", 32'(bus.ps2_key_o), 32'h000);
    check_eq("rst_err", 32'(bus.err_o), 32'h0);
    reset = 1'b0;
    repeat (20) @(negedge clk_sys);
    check_eq("idle_err", err_cnt, 0);

    // Falling edge with data high in idle: ignored, no error.
    ps2_bit(1'b1);
    repeat (40) @(negedge clk_sys);
    check_eq("noise_err", err_cnt, 0);
    check_eq("noise_chg", chg_cnt, 0);

    send_frame(8'h1C, 1'b0, 1'b1);
    check_eq("make_1c_key", 32'(bus.ps2_key_o), 32'h61C);
    check_eq("make_1c_chg", chg_cnt, 1);
    check_eq("make_1c_err", err_cnt, 0);

    send_frame(8'hF0, 1'b0, 1'b1);
    check_eq("f0_key", 32'(bus.ps2_key_o), 32'h61C);
    check_eq("f0_chg", chg_cnt, 1);
    send_frame(8'h1C, 1'b0, 1'b1);
    check_eq("brk_1c_key", 32'(bus.ps2_key_o), 32'h01C);
    check_eq("brk_1c_chg", chg_cnt, 2);

    send_frame(8'hE0, 1'b0, 1'b1);
    send_frame(8'h75, 1'b0, 1'b1);
    check_eq("ext_75_key", 32'(bus.ps2_key_o), 32'h775);
    send_frame(8'hE0, 1'b0, 1'b1);
    send_frame(8'hF0, 1'b0, 1'b1);
    send_frame(8'h75, 1'b0, 1'b1);
    check_eq("ext_brk_75_key", 32'(bus.ps2_key_o), 32'h175);
    check_eq("ext_brk_75_chg", chg_cnt, 4);

    // Wrong parity.
    send_frame(8'h1C, 1'b1, 1'b1);
`ifdef PS2_KEY_PARITY_CHECK_EN
    exp_err = 1;
    check_eq("par_key", 32'(bus.ps2_key_o), 32'h175);
`else
    exp_err = 0;
    check_eq("par_key", 32'(bus.ps2_key_o), 32'h61C);
`endif
    check_eq("par_err", err_cnt, exp_err);

    // E0 prefix, then a frame with a bad stop bit clears it, then 0x75.
    send_frame(8'hE0, 1'b0, 1'b1);
    chg0 = chg_cnt;
    send_frame(8'h33, 1'b0, 1'b0);
    exp_err++;
    check_eq("stop_err", err_cnt, exp_err);
    check_eq("stop_chg", chg_cnt, chg0);
    send_frame(8'h75, 1'b0, 1'b1);
`ifdef PS2_KEY_PARITY_CHECK_EN
    check_eq("err_clr_ext_key", 32'(bus.ps2_key_o), 32'h675);
`else
    check_eq("err_clr_ext_key", 32'(bus.ps2_key_o), 32'h275);
`endif

    // Timeout: start bit plus 4 data bits, then silence.
    chg0 = chg_cnt;
    ps2_bit(1'b0);
    ps2_bit(1'b1);
    ps2_bit(1'b0);
    ps2_bit(1'b1);
    ps2_bit(1'b1);
    bus.ps2_data_i = 1'b1;
    repeat (TimeoutCycles + 40) @(negedge clk_sys);
    exp_err++;
    check_eq("tmo_err", err_cnt, exp_err);
    check_eq("tmo_chg", chg_cnt, chg0);
    send_frame(8'h29, 1'b0, 1'b1);
`ifdef PS2_KEY_PARITY_CHECK_EN
    check_eq("tmo_29_key", 32'(bus.ps2_key_o), 32'h229);
`else
    check_eq("tmo_29_key", 32'(bus.ps2_key_o), 32'h629);
`endif

    // Reset mid-frame after an E0 prefix.
    send_frame(8'hE0, 1'b0, 1'b1);
    ps2_bit(1'b0);
    ps2_bit(1'b1);
    ps2_bit(1'b0);
    @(negedge clk_sys);
    reset = 1'b1;
    @(negedge clk_sys);
    check_eq("mid_rst_key", 32'(bus.ps2_key_o), 32'h000);
    reset = 1'b0;
    bus.ps2_data_i = 1'b1;
    repeat (40) @(negedge clk_sys);
    send_frame(8'h6B, 1'b0, 1'b1);
    check_eq("mid_rst_6b_key", 32'(bus.ps2_key_o), 32'h66B);
    check_eq("mid_rst_err", err_cnt, exp_err);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
